// File: rtl/dense_pkg.sv
// rtl/dense_pkg.sv - shared types and sizing helpers for the dense activation serializer
package dense_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Number of VEC_SIZE-wide beats in one captured frame
  function automatic int calc_num_beats(input int output_size, input int vec_size);
    return output_size / vec_size;
  endfunction

  // Beat index width; never narrower than one bit
  function automatic int calc_beat_w(input int num_beats);
    return (num_beats > 1) ? $clog2(num_beats) : 1;
  endfunction

  // A frame must split into whole beats
  function automatic bit frame_size_ok(input int output_size, input int vec_size);
    return (vec_size > 0) && (output_size >= vec_size) && ((output_size % vec_size) == 0);
  endfunction

endpackage

// File: rtl/act_quant.sv
// rtl/act_quant.sv - one-element bias add, arithmetic shift, optional ReLU and saturation
module act_quant
  import dense_pkg::*;
#(
  parameter int BW_ACC   = 29,
  parameter int BW_BIAS  = 16,
  parameter int BW_OUT   = 16,
  parameter int R_SHIFT  = 0,
  parameter int USE_RELU = 1
) (
  input  logic signed [BW_ACC-1:0]  acc,
  input  logic signed [BW_BIAS-1:0] bias,
  output logic        [BW_OUT-1:0]  q,
  output logic                      sat
);

  // Sum width cannot overflow; the working width also covers BW_OUT so the
  // clamp limits are representable whichever operand is wider.
  localparam int SW = ((BW_ACC > BW_BIAS) ? BW_ACC : BW_BIAS) + 1;
  localparam int WW = ((SW > BW_OUT) ? SW : BW_OUT) + 1;

  localparam logic signed [WW-1:0] ONE   = {{(WW-1){1'b0}}, 1'b1};
  localparam logic signed [WW-1:0] MAX_V = (ONE <<< (BW_OUT-1)) - ONE;
  localparam logic signed [WW-1:0] MIN_V = -(ONE <<< (BW_OUT-1));

  logic signed [WW-1:0] sum;
  logic signed [WW-1:0] shifted;
  logic signed [WW-1:0] relu_v;

  // Bias add, floor shift, ReLU, then clamp; ReLU zeroing is not a saturation event
  always_comb begin
    sum     = WW'(acc) + WW'(bias);
    shifted = sum >>> R_SHIFT;
    relu_v  = shifted;
    if ((USE_RELU != 0) && (shifted < 0)) begin
      relu_v = '0;
    end
    q   = relu_v[BW_OUT-1:0];
    sat = 1'b0;
    if (relu_v > MAX_V) begin
      q   = MAX_V[BW_OUT-1:0];
      sat = 1'b1;
    end else if (relu_v < MIN_V) begin
      q   = MIN_V[BW_OUT-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/dense_act_serializer.sv
// rtl/dense_act_serializer.sv - captures a dense-layer frame and streams quantised activation beats
module dense_act_serializer
  import dense_pkg::*;
#(
  parameter int OUTPUT_SIZE = 128,
  parameter int VEC_SIZE    = 4,
  parameter int BW_ACC      = 29,
  parameter int BW_BIAS     = 16,
  parameter int BW_OUT      = 16,
  parameter int R_SHIFT     = 0,
  parameter int USE_RELU    = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 vld_in,
  input  logic [OUTPUT_SIZE-1:0][BW_ACC-1:0]   data_in,
  input  logic [OUTPUT_SIZE-1:0][BW_BIAS-1:0]  bias,
  input  logic                                 rdy_in,
  output logic                                 vld_out,
  output logic [VEC_SIZE-1:0][BW_OUT-1:0]      data_out,
  output logic                                 last_out,
  output logic                                 busy,
  output logic                                 sat_flag,
  output logic                                 drop_err
);

  localparam int NUM_BEATS = calc_num_beats(OUTPUT_SIZE, VEC_SIZE);
  localparam int BEAT_W    = calc_beat_w(NUM_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  if (!frame_size_ok(OUTPUT_SIZE, VEC_SIZE)) begin : g_bad_size
    $error("dense_act_serializer: OUTPUT_SIZE must be a positive multiple of VEC_SIZE");
  end

  state_t                                      state;
  logic [BEAT_W-1:0]                           beat_idx;
  logic                                        last_loaded;
  logic [NUM_BEATS-1:0][VEC_SIZE-1:0][BW_ACC-1:0]  cap_buf;
  logic [NUM_BEATS-1:0][VEC_SIZE-1:0][BW_BIAS-1:0] bias_beats;
  logic [VEC_SIZE-1:0][BW_OUT-1:0]             lane_q;
  logic [VEC_SIZE-1:0]                         lane_sat;
  logic                                        capture;
  logic                                        load;

  assign bias_beats = bias;

  // New frames are only taken while idle; the output register refills when empty or draining
  assign capture = (state == IDLE) && vld_in;
  assign load    = (state == STREAM) && !last_loaded && (!vld_out || rdy_in);

  for (genvar j = 0; j < VEC_SIZE; j++) begin : g_lane
    act_quant #(
      .BW_ACC  (BW_ACC),
      .BW_BIAS (BW_BIAS),
      .BW_OUT  (BW_OUT),
      .R_SHIFT (R_SHIFT),
      .USE_RELU(USE_RELU)
    ) u_act_quant (
      .acc (cap_buf[beat_idx][j]),
      .bias(bias_beats[beat_idx][j]),
      .q   (lane_q[j]),
      .sat (lane_sat[j])
    );
  end

  // Capture buffer: frame payload, no reset needed
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_buf <= data_in;
    end
  end

  // Output payload register: follows each beat load, contents don't-care when not valid
  always_ff @(posedge clk) begin
    if (load) begin
      data_out <= lane_q;
    end
  end

  // Control FSM: capture, beat sequencing, handshake and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat_idx    <= '0;
      last_loaded <= 1'b0;
      vld_out     <= 1'b0;
      last_out    <= 1'b0;
      busy        <= 1'b0;
      sat_flag    <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vld_in) begin
            state       <= STREAM;
            beat_idx    <= '0;
            last_loaded <= 1'b0;
            busy        <= 1'b1;
            sat_flag    <= 1'b0;
          end
        end
        STREAM: begin
          if (vld_in) begin
            drop_err <= 1'b1;
          end
          if (load) begin
            vld_out <= 1'b1;
            if (beat_idx == LAST_BEAT) begin
              last_out    <= 1'b1;
              last_loaded <= 1'b1;
            end else begin
              last_out <= 1'b0;
              beat_idx <= beat_idx + BEAT_W'(1);
            end
            if (|lane_sat) begin
              sat_flag <= 1'b1;
            end
          end else if (vld_out && rdy_in) begin
            vld_out  <= 1'b0;
            last_out <= 1'b0;
            if (last_loaded) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_act_serializer.sv
// tb/tb_dense_act_serializer.sv - scoreboard bench for dense_act_serializer
module tb_dense_act_serializer;

  localparam int OS  = 8;
  localparam int VS  = 4;
  localparam int BA  = 29;
  localparam int BB  = 16;
  localparam int BO  = 16;
  localparam int RS  = 2;
  localparam int RL  = 1;
  localparam int NB  = OS / VS;

  logic                      clk;
  logic                      rst_n;
  logic                      vld_in;
  logic [OS-1:0][BA-1:0]     data_in;
  logic [OS-1:0][BB-1:0]     bias;
  logic                      rdy_in;
  logic                      vld_out;
  logic [VS-1:0][BO-1:0]     data_out;
  logic                      last_out;
  logic                      busy;
  logic                      sat_flag;
  logic                      drop_err;

  dense_act_serializer #(
    .OUTPUT_SIZE(OS), .VEC_SIZE(VS), .BW_ACC(BA), .BW_BIAS(BB),
    .BW_OUT(BO), .R_SHIFT(RS), .USE_RELU(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .data_in(data_in), .bias(bias),
    .rdy_in(rdy_in), .vld_out(vld_out), .data_out(data_out), .last_out(last_out),
    .busy(busy), .sat_flag(sat_flag), .drop_err(drop_err)
  );

  typedef struct {
    logic [VS*BO-1:0] data;
    bit               last;
    bit               sat;
  } beat_t;

  beat_t  sb[$];
  int     n_vec  = 0;
  int     n_miss = 0;
  longint acc_v[OS];
  longint bias_v[OS];
  bit     stalled = 0;
  logic [VS*BO-1:0] held_data;
  logic   held_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: element value from plain integer arithmetic (floor divide, clamp)
  function automatic void ref_elem(input longint a, input longint b, output longint v, output bit s);
    longint sum, div, t, hi, lo;
    sum = a + b;
    div = longint'(1) << RS;
    if (sum >= 0) t = sum / div;
    else          t = -((-sum + div - 1) / div);
    if (RL != 0 && t < 0) t = 0;
    hi = (longint'(1) << (BO - 1)) - 1;
    lo = -(longint'(1) << (BO - 1));
    s = 0;
    if (t > hi) begin t = hi; s = 1; end
    else if (t < lo) begin t = lo; s = 1; end
    v = t;
  endfunction

  function automatic longint rnd_acc();
    if ($urandom_range(0, 1) == 0)
      return longint'($urandom_range(0, 400000)) - 200000;
    return longint'($signed(BA'($urandom)));
  endfunction

  task automatic fill_random(input bit new_bias);
    for (int i = 0; i < OS; i++) begin
      acc_v[i] = rnd_acc();
      if (new_bias) bias_v[i] = longint'($signed(BB'($urandom)));
    end
  endtask

  // Issue vld_in for one cycle; caller is at posedge+1, returns at E0+1
  task automatic start_frame(input bit accept);
    longint v;
    bit     s;
    bit     fsat;
    beat_t  it;
    for (int i = 0; i < OS; i++) begin
      data_in[i] = BA'(acc_v[i]);
      bias[i]    = BB'(bias_v[i]);
    end
    vld_in = 1'b1;
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    if (accept) begin
      fsat = 0;
      for (int i = 0; i < OS; i++) begin
        ref_elem(acc_v[i], bias_v[i], v, s);
        fsat |= s;
      end
      for (int k = 0; k < NB; k++) begin
        it.data = '0;
        for (int j = 0; j < VS; j++) begin
          ref_elem(acc_v[k*VS+j], bias_v[k*VS+j], v, s);
          it.data[j*BO +: BO] = v[BO-1:0];
        end
        it.last = (k == NB - 1);
        it.sat  = fsat;
        sb.push_back(it);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic wait_vld(input string name);
    int n = 0;
    while (!vld_out && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check(name, 64'(vld_out), 64'd1);
  endtask

  // Monitor: hold-stability under backpressure and scoreboard pop on each accepted beat
  always @(negedge clk) begin
    beat_t it;
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        check("hold_vld", 64'(vld_out), 64'd1);
        check("hold_data", 64'(data_out), 64'(held_data));
        check("hold_last", 64'(last_out), 64'(held_last));
      end
      if (vld_out && rdy_in) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_beat: got data %0h with nothing expected", data_out);
        end else begin
          it = sb.pop_front();
          check("beat_data", 64'(data_out), 64'(it.data));
          check("beat_last", 64'(last_out), 64'(it.last));
          if (it.last) check("frame_sat", 64'(sat_flag), 64'(it.sat));
        end
      end
      stalled   = vld_out && !rdy_in;
      held_data = data_out;
      held_last = last_out;
    end
  end

  initial begin
    rst_n   = 1'b0;
    vld_in  = 1'b0;
    rdy_in  = 1'b1;
    data_in = '0;
    bias    = '0;
    for (int i = 0; i < OS; i++) begin acc_v[i] = 0; bias_v[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld_out", 64'(vld_out), 64'd0);
    check("rst_last_out", 64'(last_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sat_flag", 64'(sat_flag), 64'd0);
    check("rst_drop_err", 64'(drop_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame with cycle-exact timing
    for (int i = 0; i < OS; i++) begin acc_v[i] = 100 * i; bias_v[i] = 0; end
    start_frame(1);
    check("basic_busy_e0", 64'(busy), 64'd1);
    check("basic_vld_e0", 64'(vld_out), 64'd0);
    @(posedge clk); #1;
    check("basic_vld_e1", 64'(vld_out), 64'd1);
    check("basic_last_e1", 64'(last_out), 64'd0);
    check("basic_beat0", 64'(data_out), 64'h004b_0032_0019_0000);
    @(posedge clk); #1;
    check("basic_last_e2", 64'(last_out), 64'd1);
    check("basic_beat1", 64'(data_out), 64'h00af_0096_007d_0064);
    @(posedge clk); #1;
    check("basic_busy_e3", 64'(busy), 64'd0);
    check("basic_vld_e3", 64'(vld_out), 64'd0);
    check("basic_sat", 64'(sat_flag), 64'd0);

    // Bias, ReLU and saturation
    acc_v  = '{-400, 1 << 20, 7, 0, 0, 0, 0, 0};
    bias_v = '{0, 0, 1, -1, 0, 0, 0, 0};
    start_frame(1);
    @(posedge clk); #1;
    check("relu_sat_beat0", 64'(data_out), 64'h0000_0002_7fff_0000);
    wait_idle("relu_sat_idle");
    check("relu_sat_flag", 64'(sat_flag), 64'd1);

    // Backpressure: stall five cycles on beat0
    for (int i = 0; i < OS; i++) begin acc_v[i] = 37 * i - 50; bias_v[i] = i; end
    rdy_in = 1'b0;
    start_frame(1);
    wait_vld("bp_first_vld");
    repeat (5) begin @(posedge clk); #1; end
    rdy_in = 1'b1;
    wait_idle("bp_idle");

    // Drop: second pulse one cycle later is ignored, third after idle accepted
    fill_random(1);
    start_frame(1);
    fill_random(0);
    start_frame(0);
    check("drop_err_set", 64'(drop_err), 64'd1);
    wait_idle("drop_idle");
    fill_random(0);
    start_frame(1);
    wait_idle("drop_third_idle");
    check("drop_err_sticky", 64'(drop_err), 64'd1);

    // Reset mid-stream while beat0 is stalled
    acc_v  = '{0, 1 << 20, 0, 0, 0, 0, 0, 0};
    bias_v = '{0, 0, 0, 0, 0, 0, 0, 0};
    rdy_in = 1'b0;
    start_frame(1);
    wait_vld("rst_mid_vld");
    @(posedge clk); #1;
    check("rst_mid_sat_before", 64'(sat_flag), 64'd1);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_vld_async", 64'(vld_out), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_sat", 64'(sat_flag), 64'd0);
    check("rst_mid_drop", 64'(drop_err), 64'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    rdy_in = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_no_beats", 64'(vld_out), 64'd0);
    for (int i = 0; i < OS; i++) begin acc_v[i] = 100 * i; bias_v[i] = 0; end
    start_frame(1);
    wait_idle("rst_mid_new_idle");
    check("rst_mid_new_sat", 64'(sat_flag), 64'd0);

    // Back-to-back: pulse on the cycle after busy falls
    for (int f = 0; f < 4; f++) begin
      fill_random(f == 0);
      start_frame(1);
      @(posedge clk); #1;
      check("b2b_latency", 64'(vld_out), 64'd1);
      wait_idle("b2b_idle");
    end

    // Randomised frames with random downstream readiness
    for (int f = 0; f < 20; f++) begin
      int n = 0;
      fill_random(1);
      rdy_in = ($urandom_range(0, 3) != 0);
      start_frame(1);
      while (busy && n < 300) begin
        @(posedge clk); #1;
        rdy_in = ($urandom_range(0, 3) != 0);
        n++;
      end
      check("rand_idle", 64'(busy), 64'd0);
      rdy_in = 1'b1;
    end

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
